// File: rtl/bsmodred_sipo.sv
// Bit-serial receiver that reduces an incoming serial frame modulo MOD on the fly
// and presents the residue as a parallel word with a one-cycle osync strobe.
module bsmodred_sipo #(
  parameter int              LEN       = 188,
  parameter int              MW        = 94,
  parameter logic [MW-1:0]   MOD       = MW'(29),
  parameter bit              MSB_FIRST = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i,
  input  logic          isync,
  output logic [MW-1:0] s,
  output logic          osync,
  output logic          busy
);

  localparam int            CW    = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [MW:0]   MOD_X = {1'b0, MOD};
  localparam logic [MW-1:0] ONE   = MW'(1);

  typedef enum logic {IDLE, RECV} state_t;

  state_t          state_q, state_d;
  logic [MW-1:0]   acc_q, acc_d;
  logic [MW-1:0]   pw_q, pw_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [MW-1:0]   s_q, s_d;
  logic            osync_q, osync_d;
  logic            busy_q, busy_d;

  logic [MW-1:0]   acc_base, pw_base;
  logic [MW-1:0]   acc_nxt, pw_nxt;
  logic            last_bit;

  // Inputs are always below 2*MOD, so a single subtract brings them into [0, MOD).
  function automatic logic [MW-1:0] cond_sub(input logic [MW:0] v);
    logic [MW:0] diff;
    diff = v - MOD_X;
    return (v >= MOD_X) ? diff[MW-1:0] : v[MW-1:0];
  endfunction

  // isync always marks bit 0, so the accumulator and weight restart from 0 and 1.
  always_comb begin
    acc_base = isync ? '0 : acc_q;
    pw_base  = isync ? ONE : pw_q;
    if (MSB_FIRST) begin
      acc_nxt = cond_sub({acc_base, i});
      pw_nxt  = pw_base;
    end else begin
      acc_nxt = cond_sub({1'b0, acc_base} + (i ? {1'b0, pw_base} : '0));
      pw_nxt  = cond_sub({pw_base, 1'b0});
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    pw_d     = pw_q;
    cnt_d    = cnt_q;
    s_d      = s_q;
    osync_d  = 1'b0;
    busy_d   = busy_q;
    last_bit = (cnt_q == CW'(LEN - 1));

    if (isync) begin
      acc_d = acc_nxt;
      pw_d  = pw_nxt;
      if (LEN == 1) begin
        s_d     = acc_nxt;
        osync_d = 1'b1;
        state_d = IDLE;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end else begin
        state_d = RECV;
        busy_d  = 1'b1;
        cnt_d   = CW'(1);
      end
    end else if (state_q == RECV) begin
      acc_d = acc_nxt;
      pw_d  = pw_nxt;
      if (last_bit) begin
        s_d     = acc_nxt;
        osync_d = 1'b1;
        state_d = IDLE;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      pw_q    <= ONE;
      cnt_q   <= '0;
      s_q     <= '0;
      osync_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      pw_q    <= pw_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      osync_q <= osync_d;
      busy_q  <= busy_d;
    end
  end

  assign s     = s_q;
  assign osync = osync_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_bsmodred_sipo.sv
// Self-checking bench: an LSB-first and an MSB-first instance receive the same frame
// values, and each residue is compared against frame % MOD computed on the full word.
module tb_bsmodred_sipo;

  localparam int            LEN = 188;
  localparam int            MW  = 94;
  localparam logic [MW-1:0] MOD = 94'd29;

  logic          clk = 1'b0;
  logic          reset;
  logic          isync, i_l, i_m;
  logic [MW-1:0] s_l, s_m;
  logic          osync_l, osync_m, busy_l, busy_m;

  int            checks = 0;
  int            errors = 0;
  logic [MW-1:0] s_exp;

  always #5 clk = ~clk;

  bsmodred_sipo #(.LEN(LEN), .MW(MW), .MOD(MOD), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(reset), .i(i_l), .isync(isync),
    .s(s_l), .osync(osync_l), .busy(busy_l)
  );

  bsmodred_sipo #(.LEN(LEN), .MW(MW), .MOD(MOD), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset(reset), .i(i_m), .isync(isync),
    .s(s_m), .osync(osync_m), .busy(busy_m)
  );

  task automatic check(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [MW-1:0] ref_mod(input logic [LEN-1:0] f);
    logic [LEN-1:0] r;
    r = f % LEN'(MOD);
    return r[MW-1:0];
  endfunction

  // Drive one clock's inputs, then sample at the following falling edge.
  task automatic cyc(input logic sy, input logic il, input logic im);
    isync = sy;
    i_l   = il;
    i_m   = im;
    @(negedge clk);
  endtask

  // Send the first nbits of frame f; a full frame must complete with the reference residue.
  task automatic send(input logic [LEN-1:0] f, input int nbits, input string tag);
    int bad;
    bad = 0;
    for (int j = 0; j < nbits; j++) begin
      cyc(j == 0, f[j], f[LEN-1-j]);
      if (j < LEN - 1) begin
        if (osync_l !== 1'b0 || osync_m !== 1'b0 || busy_l !== 1'b1 || busy_m !== 1'b1 ||
            s_l !== s_exp || s_m !== s_exp)
          bad++;
      end
    end
    check({tag, " in-frame glitches"}, MW'(bad), MW'(0));
    if (nbits == LEN) begin
      s_exp = ref_mod(f);
      check({tag, " osync lsb"}, MW'(osync_l), MW'(1));
      check({tag, " osync msb"}, MW'(osync_m), MW'(1));
      check({tag, " s lsb"}, s_l, s_exp);
      check({tag, " s msb"}, s_m, s_exp);
      check({tag, " busy lsb"}, MW'(busy_l), MW'(0));
      check({tag, " busy msb"}, MW'(busy_m), MW'(0));
    end
  endtask

  // Idle cycles with random data: i must be ignored and outputs must hold.
  task automatic idle(input int n, input string tag);
    int bad;
    bad = 0;
    for (int j = 0; j < n; j++) begin
      cyc(1'b0, 1'($urandom), 1'($urandom));
      if (osync_l !== 1'b0 || osync_m !== 1'b0 || busy_l !== 1'b0 || busy_m !== 1'b0 ||
          s_l !== s_exp || s_m !== s_exp)
        bad++;
    end
    check({tag, " idle hold"}, MW'(bad), MW'(0));
  endtask

  function automatic logic [LEN-1:0] rand_frame();
    logic [LEN-1:0] f;
    for (int k = 0; k < LEN; k++) f[k] = 1'($urandom);
    return f;
  endfunction

  initial begin
    logic [LEN-1:0] f;
    reset = 1'b0;
    isync = 1'b0;
    i_l   = 1'b0;
    i_m   = 1'b0;
    s_exp = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset s lsb", s_l, MW'(0));
    check("reset s msb", s_m, MW'(0));
    check("reset osync", MW'({osync_l, osync_m}), MW'(0));
    check("reset busy", MW'({busy_l, busy_m}), MW'(0));
    reset = 1'b1;
    idle(2, "post-reset");

    send(LEN'(16), LEN, "value16");
    idle(1, "after16");
    f = '1;
    send(f, LEN, "allones");
    check("allones literal", s_l, MW'(22));
    send(LEN'(29), LEN, "value29");
    idle(3, "after29");

    send(LEN'(58), LEN, "value58");
    send(LEN'(45), LEN, "value45");
    check("value45 literal", s_m, MW'(16));
    idle(2, "after45");

    send(LEN'(16), 100, "abortA");
    send(LEN'(3), LEN, "abortB");
    check("abortB literal", s_l, MW'(3));

    send(LEN'(5), LEN, "b2b5");
    send(LEN'(35), LEN, "b2b35");
    check("b2b35 literal", s_l, MW'(6));
    idle(2, "afterb2b");

    for (int n = 0; n < 6; n++) begin
      if ($urandom_range(0, 2) == 0) send(rand_frame(), int'($urandom_range(1, LEN - 1)), "rand-abort");
      send(rand_frame(), LEN, "random");
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)), "random gap");
    end

    send(rand_frame(), 50, "prereset");
    #2 reset = 1'b0;
    #1;
    s_exp = '0;
    check("midreset s lsb", s_l, MW'(0));
    check("midreset s msb", s_m, MW'(0));
    check("midreset osync", MW'({osync_l, osync_m}), MW'(0));
    check("midreset busy", MW'({busy_l, busy_m}), MW'(0));
    @(negedge clk);
    reset = 1'b1;
    idle(LEN, "postreset wait");
    send(LEN'(30), LEN, "value30");
    check("value30 literal", s_m, MW'(1));
    idle(2, "final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
